pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Each cycle, generates the per-stage en/flush strobes from three inputs: I-cache and D-cache completion, the load-use hazard flag, and the branch/jump redirect from EX.
- Tracks which cache has already responded during a multi-cycle stall, so that no request is reissued or lost.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_WIDTH, 32, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- imem_resp  in  1  I-cache response valid (one-cycle pulse)
- dmem_req  in  1  instruction in EX/MEM performs a load or store
- dmem_resp  in  1  D-cache response valid (one-cycle pulse)
- load_use  in  1  ID instruction sources the rd of a load in ID/EX
- redirect  in  1  EX resolves a taken branch or jump (PC mux selects the target)
- imem_read  out  1  I-cache request enable
- dmem_en  out  1  D-cache request enable (gates read/write)
- pc_en  out  1  PC load enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush  out  1 each  zero the register when en and flush are both set
- stall_cnt  out  CNT_WIDTH  cycles with advance=0 while in RUN
- flush_cnt  out  CNT_WIDTH  cycles with redirect applied

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - rst is synchronous and active-high, and has priority over everything, including mid-stall.
  - Reset values: state=INIT, i_done_q=0, d_done_q=0, stall_cnt=0, flush_cnt=0.
- INIT state (first cycle after rst deasserts):
  - All enables 0. ifid_flush=idex_flush=1. imem_read=0. dmem_en=0.
  - Next state is RUN unconditionally.
- RUN state, combinational terms:
  - i_ok = imem_resp | i_done_q
  - d_ok = ~dmem_req | dmem_resp | d_done_q
  - advance = i_ok & d_ok
- Cache request gating:
  - imem_read = ~i_done_q.
  - dmem_en = dmem_req & ~d_done_q.
  - A cache that has already responded is never re-requested within the same stall.
- Sticky flags:
  - If advance=0: i_done_q sets on imem_resp and d_done_q sets on dmem_resp; a flag that is already set holds.
  - If advance=1: both flags clear.
  - Both responses arriving in the same cycle gives advance=1 and the flags stay clear.
- Stall (advance=0): every en=0, every flush=0, PC held.
- Advance with no hazard: every en=1, every flush=0.
- Load-use, when advance & load_use & ~redirect:
  - pc_en=0, ifid_en=0 (the fetch is repeated next cycle).
  - idex_en=1 with idex_flush=1 (bubble inserted).
  - exmem_en=1, memwb_en=1.
- Redirect, when advance & redirect:
  - pc_en=1 (target loads).
  - ifid_en=idex_en=1 with ifid_flush=idex_flush=1.
  - exmem_en=1, memwb_en=1.
  - Redirect overrides load_use, because the ID instruction is on the wrong path.
- Redirect or load_use without advance: ignored that cycle. The inputs are held by the stalled stages and are re-evaluated in the cycle that advances.
- Counters:
  - stall_cnt increments in every RUN cycle with advance=0.
  - flush_cnt increments on every applied redirect.
  - Both saturate at all-ones and never wrap.
- The block has no other states. Latency from the last outstanding response to the enables asserting is 0 cycles (combinational in the same cycle).

Test Plan:
- Reset then idle fetch: rst 2 cycles, then imem_resp every cycle with dmem_req=0 -> INIT cycle has all en=0 and flush=1; from the next cycle all en=1 every cycle; stall_cnt=0.
- I-miss while a D-access is pending: dmem_req=1, dmem_resp at cycle 2, imem_resp at cycle 5 -> en=0 in cycles 0-4; dmem_en drops after cycle 2; all en=1 at cycle 5; stall_cnt=5; flags clear at cycle 6.
- Simultaneous responses: imem_resp and dmem_resp both in cycle 3 with dmem_req=1 -> advance in cycle 3; neither flag ever sets; stall_cnt=3.
- Load-use: load_use=1 on an advancing cycle -> pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1; next cycle with load_use=0 gives all en=1.
- Redirect together with load_use while advancing -> pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt increments by 1. With redirect=1 during a stall -> no flush and flush_cnt unchanged until the advancing cycle.
- Reset mid-stall with i_done_q=1, plus counter saturation (CNT_WIDTH=4, 20 stall cycles) -> after rst, flags=0, counters=0, state INIT; in the saturation run stall_cnt holds at 15.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencer: derives per-stage enable/flush strobes from cache completion,
// load-use and redirect, remembers which cache already answered during a stall.
module pipeline_stall_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 load_use,
  input  logic                 redirect,
  output logic                 imem_read,
  output logic                 dmem_en,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 i_ok, d_ok, advance;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  assign i_ok    = imem_resp | i_done_q;
  assign d_ok    = ~dmem_req | dmem_resp | d_done_q;
  assign advance = i_ok & d_ok;

  always_comb begin
    state_d     = state_q;
    i_done_d    = i_done_q;
    d_done_d    = d_done_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    imem_read   = 1'b0;
    dmem_en     = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    case (state_q)
      ST_INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        imem_read = ~i_done_q;
        dmem_en   = dmem_req & ~d_done_q;
        if (advance) begin
          i_done_d = 1'b0;
          d_done_d = 1'b0;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          // Redirect wins over load-use: the ID instruction is on the wrong path.
          if (redirect) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_d = sat_inc(flush_cnt_q);
          end else if (load_use) begin
            idex_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end else begin
          i_done_d    = i_done_q | imem_resp;
          d_done_d    = d_done_q | dmem_resp;
          stall_cnt_d = sat_inc(stall_cnt_q);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, hand sequences for reset and
// counter saturation, then random traffic against a cycle-level reference model.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, imem_resp, dmem_req, dmem_resp, load_use, redirect;
  logic imem_read, dmem_en, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic imem_read4, dmem_en4, pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_flush4, idex_flush4;
  logic [3:0] stall_cnt4, flush_cnt4;
  logic [8:0] outs;

  pipeline_stall_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_use(load_use), .redirect(redirect), .imem_read(imem_read), .dmem_en(dmem_en),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_stall_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .load_use(load_use), .redirect(redirect), .imem_read(imem_read4), .dmem_en(dmem_en4),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
    .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  assign outs = {imem_read, dmem_en, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: in_init, "has the I/D side been satisfied since the last advance",
  // and raw event counts (saturation applied only when comparing).
  bit     m_init = 1'b1;
  bit     m_i_seen, m_d_seen;
  longint m_stalls, m_flushes;

  function automatic bit m_go();
    bit fetched, mem_ready;
    fetched   = imem_resp || m_i_seen;
    mem_ready = !dmem_req || dmem_resp || m_d_seen;
    return fetched && mem_ready;
  endfunction

  function automatic logic [8:0] m_outs();
    logic rd_i, rd_d;
    if (m_init) return 9'b000000011;
    rd_i = !m_i_seen;
    rd_d = dmem_req && !m_d_seen;
    if (!m_go())       return {rd_i, rd_d, 7'b0000000};
    if (redirect)      return {rd_i, rd_d, 7'b1111111};
    if (load_use)      return {rd_i, rd_d, 7'b0011101};
    return {rd_i, rd_d, 7'b1111100};
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive(input logic r, ir, dq, dr, lu, rd);
    rst = r; imem_resp = ir; dmem_req = dq; dmem_resp = dr; load_use = lu; redirect = rd;
    #1;
  endtask

  task automatic tick();
    bit go;
    go = m_go();
    @(posedge clk);
    if (rst) begin
      m_init = 1'b1; m_i_seen = 1'b0; m_d_seen = 1'b0; m_stalls = 0; m_flushes = 0;
    end else if (m_init) begin
      m_init = 1'b0;
    end else if (!go) begin
      m_stalls++;
      if (imem_resp) m_i_seen = 1'b1;
      if (dmem_resp) m_d_seen = 1'b1;
    end else begin
      m_i_seen = 1'b0; m_d_seen = 1'b0;
      if (redirect) m_flushes++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic       r, ir, dq, dr, lu, rd, ck;
    logic [8:0] eo;
    int         es, ef;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, ir, dq, dr, lu, rd, ck, input logic [8:0] eo, input int es, ef);
    vec_t v;
    v.r = r; v.ir = ir; v.dq = dq; v.dr = dr; v.lu = lu; v.rd = rd; v.ck = ck;
    v.eo = eo; v.es = es; v.ef = ef;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0; load_use = 1'b0; redirect = 1'b0;
    //   r  ir dq dr lu rd ck  outs          stall flush
    add(1, 0, 0, 0, 0, 0, 0, 9'b000000000, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 9'b000000000, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 9'b000000011, 0, 0);   // INIT
    add(0, 1, 0, 0, 0, 0, 1, 9'b101111100, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 9'b101111100, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 9'b101111100, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 9'b110000000, 0, 0);   // I-miss with D pending
    add(0, 0, 1, 0, 0, 0, 1, 9'b110000000, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1, 9'b110000000, 2, 0);
    add(0, 0, 1, 0, 0, 0, 1, 9'b100000000, 3, 0);
    add(0, 0, 1, 0, 0, 0, 1, 9'b100000000, 4, 0);
    add(0, 1, 1, 0, 0, 0, 1, 9'b101111100, 5, 0);
    add(0, 0, 1, 0, 0, 0, 1, 9'b110000000, 5, 0);
    add(0, 0, 1, 0, 0, 0, 1, 9'b110000000, 6, 0);   // simultaneous responses
    add(0, 0, 1, 0, 0, 0, 1, 9'b110000000, 7, 0);
    add(0, 0, 1, 0, 0, 0, 1, 9'b110000000, 8, 0);
    add(0, 1, 1, 1, 0, 0, 1, 9'b111111100, 9, 0);
    add(0, 0, 1, 0, 0, 0, 1, 9'b110000000, 9, 0);
    add(0, 1, 0, 0, 0, 0, 1, 9'b101111100, 10, 0);
    add(0, 1, 0, 0, 1, 0, 1, 9'b100011101, 10, 0);  // load-use
    add(0, 1, 0, 0, 0, 0, 1, 9'b101111100, 10, 0);
    add(0, 1, 0, 0, 1, 1, 1, 9'b101111111, 10, 0);  // redirect + load-use
    add(0, 1, 0, 0, 0, 0, 1, 9'b101111100, 10, 1);
    add(0, 0, 0, 0, 0, 1, 1, 9'b100000000, 10, 1);  // redirect during stall
    add(0, 1, 0, 0, 0, 1, 1, 9'b101111111, 11, 1);
    add(0, 1, 0, 0, 0, 0, 1, 9'b101111100, 11, 2);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].ir, tbl[i].dq, tbl[i].dr, tbl[i].lu, tbl[i].rd);
      if (tbl[i].ck) begin
        check($sformatf("tbl%0d_outs", i), outs, tbl[i].eo);
        check($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].es);
        check($sformatf("tbl%0d_flush", i), flush_cnt, tbl[i].ef);
      end
      tick();
    end

    // Reset in the middle of a stall with the I-side flag set
    drive(0, 1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0);
    check("midstall_imem_read", imem_read, 0);
    check("midstall_dmem_en", dmem_en, 1);
    tick();
    drive(1, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0);
    check("postrst_outs", outs, 9'b000000011);
    check("postrst_stall", stall_cnt, 0);
    check("postrst_flush", flush_cnt, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    check("postrst_flag_clear", outs, 9'b110000000);
    tick();

    // Saturation on the 4-bit counter instance
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, 0, 0, 0);
      check($sformatf("sat_stall4_%0d", k), stall_cnt4, sat(k, 15));
      check($sformatf("sat_stall32_%0d", k), stall_cnt, k);
      tick();
    end
    check("sat_stall4_hold", stall_cnt4, 15);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      check($sformatf("rnd%0d_outs", n), outs, m_outs());
      check($sformatf("rnd%0d_stall", n), stall_cnt, m_stalls);
      check($sformatf("rnd%0d_flush", n), flush_cnt, m_flushes);
      check($sformatf("rnd%0d_stall4", n), stall_cnt4, sat(m_stalls, 15));
      check($sformatf("rnd%0d_flush4", n), flush_cnt4, sat(m_flushes, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
